// File: rtl/pipeline_stage_reg_if.sv
// Handshake and status bundle for pipeline_stage_reg (valid/ready on both sides).
interface pipeline_stage_reg_if #(
    parameter int DataWidth  = 32,
    parameter int CountWidth = 16
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DataWidth-1:0]  in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DataWidth-1:0]  out_data;
    logic [1:0]            occupancy;
    logic [CountWidth-1:0] stall_count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, stall_count
    );
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, stall_count
    );
endinterface

// File: rtl/pipeline_stage_reg.sv
// Valid/ready pipeline register with stall counter. Define PIPELINE_STAGE_SKID_BUFFER_EN
// for a two-entry skid buffer whose in_ready is registered (no path from out_ready).
module pipeline_stage_reg #(
    parameter int DataWidth  = 32,
    parameter int CountWidth = 16
) (
    input logic                 clock,
    input logic                 reset,
    pipeline_stage_reg_if.slave bus
);
    localparam logic [CountWidth-1:0] CountMax = '1;

    logic                  in_ready;
    logic                  out_valid;
    logic                  accept;
    logic                  drain;
    logic [DataWidth-1:0]  main_q, main_d;
    logic [CountWidth-1:0] stall_q, stall_d;

    assign accept = bus.in_valid & in_ready;
    assign drain  = out_valid & bus.out_ready;

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = main_q;
    assign bus.stall_count = stall_q;

`ifdef PIPELINE_STAGE_SKID_BUFFER_EN
    // Encoding doubles as the entry count driven on occupancy.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DataWidth-1:0] skid_q, skid_d;
    logic                 ready_q, ready_d;

    assign in_ready      = ready_q;
    assign out_valid     = (state_q != EMPTY);
    assign bus.occupancy = state_q;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d = ONE;
                    main_d  = bus.in_data;
                end
                ONE: if (accept && drain) begin
                    main_d = bus.in_data;
                end else if (accept) begin
                    state_d = TWO;
                    skid_d  = bus.in_data;
                end else if (drain) begin
                    state_d = EMPTY;
                end
                TWO: if (drain) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
                default: state_d = EMPTY;
            endcase
        end
        ready_d = (state_d != TWO);
    end

    // NOTE: payload registers are reset too, because out_data must read 0 during reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            stall_q <= stall_d;
        end
    end
`else
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e state_q, state_d;

    assign out_valid     = (state_q == FULL);
    assign in_ready      = bus.out_ready | ~out_valid;
    assign bus.occupancy = {1'b0, state_q};

    // A full register only accepts while draining, so accept alone covers FULL->FULL.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
            main_d  = bus.in_data;
        end else if (drain) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            stall_q <= stall_d;
        end
    end
`endif

    // Flush does not clear the counter; it saturates instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !bus.out_ready && (stall_q != CountMax)) begin
            stall_d = stall_q + CountWidth'(1);
        end
    end
endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32, meaning the payload width in bits (one packed pipeline struct, e.g. if_id_t).
REQ-002 The block SHALL have parameter CountWidth, default 16, meaning the width of the stall counter.
REQ-003 The block SHALL have port clock  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  meaning an asynchronous, active-low reset.
REQ-005 The block SHALL have port flush  input  1  meaning discard all held entries at the next edge.
REQ-006 The block SHALL have port in_valid  input  1  meaning upstream payload is valid.
REQ-007 The block SHALL have port in_ready  output  1  meaning the stage accepts a payload this cycle.
REQ-008 The block SHALL have port in_data  input  DataWidth  meaning the upstream payload.
REQ-009 The block SHALL have port out_valid  output  1  meaning out_data holds a valid payload.
REQ-010 The block SHALL have port out_ready  input  1  meaning downstream accepts a payload this cycle.
REQ-011 The block SHALL have port out_data  output  DataWidth  meaning the head payload.
REQ-012 The block SHALL have port occupancy  output  2  meaning the number of entries held (0..2).
REQ-013 The block SHALL have port stall_count  output  CountWidth  meaning the number of cycles with out_valid=1 and out_ready=0.

Function
- REQ-014 A transfer SHALL occur on an input side when in_valid & in_ready, and on an output side when out_valid & out_ready, both sampled at the rising edge.
- REQ-015 Payloads SHALL leave in acceptance order, with no loss or duplication absent flush.
- REQ-016 Latency SHALL be 1 cycle: data accepted at edge N SHALL appear on out_data with out_valid=1 after edge N.
- REQ-017 out_valid SHALL be 1 exactly when occupancy != 0, and out_data SHALL be the oldest entry.
- REQ-018 Any simultaneous accept and drain SHALL leave occupancy unchanged, with the head replaced by the next payload.
- REQ-019 flush=1 at an edge SHALL set occupancy to 0, and any input transfer in that same cycle SHALL be discarded, since flush has priority.
- REQ-020 out_data SHALL hold its last value while out_valid=0, and SHALL NOT change while out_valid=1 and out_ready=0.
- REQ-021 stall_count SHALL increment by 1 at each edge where out_valid=1 and out_ready=0.
- REQ-022 stall_count SHALL saturate at 2^CountWidth-1 without wrapping.
- REQ-023 stall_count SHALL NOT be cleared by flush.
- REQ-024 occupancy SHALL never exceed 1 without the skid option (see REQ-031) and SHALL never exceed 2 with it.

Reset
- REQ-025 When reset=0, the block SHALL immediately, without waiting for clock, force out_valid=0, occupancy=0, stall_count=0 and out_data=0.
- REQ-026 Reset asserted mid-transfer SHALL discard all entries, and no payload SHALL appear after reset release until a new input transfer occurs.
- REQ-027 in_ready SHALL be 1 during reset with the skid option and SHALL be 1 (occupancy 0) without it, but no transfer SHALL be recorded while reset=0.
- REQ-028 Reset release SHALL take effect at the first rising edge with reset=1.

Configuration
- REQ-029 The macro PIPELINE_STAGE_SKID_BUFFER_EN SHALL select the buffering mode.
- REQ-030 If PIPELINE_STAGE_SKID_BUFFER_EN is undefined, the block SHALL be a single register with states EMPTY and FULL, and in_ready = out_ready | ~out_valid (combinational path from out_ready).
  - EMPTY->FULL on accept.
  - FULL->EMPTY on drain without accept.
  - FULL->FULL on accept+drain.
- REQ-031 If PIPELINE_STAGE_SKID_BUFFER_EN is defined, the block SHALL have a main register plus a skid register, with states EMPTY, ONE and TWO, and in_ready driven directly by a flop (1 unless TWO), with no combinational path from out_ready.
  - EMPTY->ONE on accept.
  - ONE->TWO on accept without drain.
  - ONE->EMPTY on drain without accept.
  - TWO->ONE on drain, with the skid entry moving to main.
- REQ-032 With the skid option, in_ready SHALL be 0 in state TWO, so no input is accepted there.

Verification
- REQ-033 Streaming: in_valid=1 with in_data=1,2,3,4 on consecutive cycles and out_ready=1 -> out_data=1,2,3,4 one cycle later, occupancy=1 throughout, stall_count=0.
- REQ-034 Backpressure: load 0xA5, hold out_ready=0 for 5 cycles -> out_data stays 0xA5 and stall_count=5.
  - Without skid: in_ready=0 during the stall.
  - With skid: second payload 0x5A accepted, occupancy=2, in_ready=0.
  - Release out_ready -> outputs 0xA5, then 0x5A.
- REQ-035 Flush collision: occupancy=1, flush=1 and in_valid=1 with in_data=0x77 at the same edge -> occupancy=0, out_valid=0, and 0x77 never appears; stall_count unchanged.
- REQ-036 Async reset: assert reset=0 mid-cycle with occupancy=2 (skid) -> out_valid=0, occupancy=0 and stall_count=0 before the next edge; after release, no output until a new input.
- REQ-037 Saturation: CountWidth=3, out_ready=0 for 10 cycles with out_valid=1 -> stall_count=7 and holds at 7.
